// File: rtl/fpu_share_scheduler.sv
// Round-robin scheduler that time-shares one strobe-less FPU adder between N_REQ requesters.
// Operands are latched and held stable for FPU_LATENCY cycles before the result is sampled.
module fpu_share_scheduler #(
   parameter int N_REQ       = 4,
   parameter int FPU_LATENCY = 5,
   parameter int STATUS_W    = 4
) (
   input  logic                     clock_100Khz,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ-1:0]         req_sub,
   input  logic [N_REQ*32-1:0]      req_op_a,
   input  logic [N_REQ*32-1:0]      req_op_b,
   output logic [N_REQ-1:0]         req_ready,
   output logic [N_REQ-1:0]         resp_valid,
   input  logic [N_REQ-1:0]         resp_ready,
   output logic [31:0]              resp_data,
   output logic [STATUS_W-1:0]      resp_status,
   output logic [31:0]              fpu_op_a,
   output logic [31:0]              fpu_op_b,
   input  logic [31:0]              fpu_data_in,
   input  logic [STATUS_W-1:0]      fpu_status_in,
   output logic                     busy,
   output logic [$clog2(N_REQ)-1:0] grant_id
);

   localparam int IDW = $clog2(N_REQ);
   localparam int CW  = $clog2(FPU_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [CW-1:0]  cnt;
   logic [IDW-1:0] winner;
   logic           found;
   logic [31:0]    sel_a;
   logic [31:0]    sel_b;
   logic           sel_sub;

   // Search starts just after the last grant so every pending requester gets a turn.
   always_comb begin
      logic [IDW-1:0] idx;
      winner  = '0;
      found   = 1'b0;
      idx     = '0;
      sel_a   = '0;
      sel_b   = '0;
      sel_sub = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = IDW'((int'(ptr) + k) % N_REQ);
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (winner == IDW'(i)) begin
            sel_a   = req_op_a[32*i +: 32];
            sel_b   = req_op_b[32*i +: 32];
            sel_sub = req_sub[i];
         end
      end
   end

   // Gated by reset so every output reads zero while reset is held.
   assign req_ready = (reset && state == IDLE && found) ? (N_REQ'(1) << winner) : '0;

   always_ff @(posedge clock_100Khz or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ptr         <= IDW'(N_REQ - 1);
         cnt         <= '0;
         fpu_op_a    <= '0;
         fpu_op_b    <= '0;
         resp_valid  <= '0;
         resp_data   <= '0;
         resp_status <= '0;
         busy        <= 1'b0;
         grant_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  fpu_op_a <= sel_a;
                  fpu_op_b <= {sel_b[31] ^ sel_sub, sel_b[30:0]};
                  grant_id <= winner;
                  ptr      <= winner;
                  cnt      <= CW'(FPU_LATENCY - 1);
                  busy     <= 1'b1;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               // Operands have now been stable for FPU_LATENCY cycles.
               if (cnt == '0) begin
                  resp_data   <= fpu_data_in;
                  resp_status <= fpu_status_in;
                  resp_valid  <= N_REQ'(1) << grant_id;
                  state       <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (resp_ready[grant_id]) begin
                  resp_valid <= '0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_share_scheduler.sv
// Directed bench for fpu_share_scheduler with an FPU stub that returns A^B only after
// the operands have been stable for FPU_LATENCY cycles and counts changes while busy.
module tb_fpu_share_scheduler;
   localparam int N  = 4;
   localparam int L  = 5;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_sub;
   logic [N*32-1:0] req_op_a;
   logic [N*32-1:0] req_op_b;
   logic [N-1:0]  req_ready;
   logic [N-1:0]  resp_valid;
   logic [N-1:0]  resp_ready;
   logic [31:0]   resp_data;
   logic [SW-1:0] resp_status;
   logic [31:0]   fpu_op_a;
   logic [31:0]   fpu_op_b;
   logic [31:0]   fpu_data_in;
   logic [SW-1:0] fpu_status_in;
   logic          busy;
   logic [1:0]    grant_id;

   int checks = 0;
   int failures = 0;
   int stub_errors = 0;
   int age = 0;
   logic [31:0] last_a = '0;
   logic [31:0] last_b = '0;
   logic        busy_prev = 1'b0;

   fpu_share_scheduler #(.N_REQ(N), .FPU_LATENCY(L), .STATUS_W(SW)) dut (
      .clock_100Khz(clk), .reset(reset),
      .req_valid(req_valid), .req_sub(req_sub), .req_op_a(req_op_a), .req_op_b(req_op_b),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_status(resp_status),
      .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
      .fpu_data_in(fpu_data_in), .fpu_status_in(fpu_status_in),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   // FPU stub: age counts negedges since the operands last changed.
   always @(negedge clk) begin
      if (fpu_op_a !== last_a || fpu_op_b !== last_b) begin
         if (busy && busy_prev) stub_errors++;
         age = 1;
      end else if (age < 1000) begin
         age++;
      end
      last_a    = fpu_op_a;
      last_b    = fpu_op_b;
      busy_prev = busy;
   end

   assign fpu_data_in   = (age >= L) ? (fpu_op_a ^ fpu_op_b) : 32'hDEADBEEF;
   assign fpu_status_in = (age >= L) ? 4'b0001 : 4'b1000;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      while (resp_valid == '0 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      resp_ready = '1;
      while (busy && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL drain_timeout busy=%0b exp=0", busy); end
      resp_ready = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0; req_valid = '0; req_sub = '0; resp_ready = '0; req_op_a = '0; req_op_b = '0;
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
      checks++;
      if ({resp_valid, req_ready} !== 8'h00) begin failures++; $display("[TB] FAIL reset_valid_ready got=%0h exp=0", {resp_valid, req_ready}); end
      checks++;
      if ({fpu_op_a, fpu_op_b} !== 64'h0) begin failures++; $display("[TB] FAIL reset_fpu_ops got=%0h exp=0", {fpu_op_a, fpu_op_b}); end
      checks++;
      if ({resp_data, resp_status, grant_id} !== 38'h0) begin failures++; $display("[TB] FAIL reset_resp got=%0h exp=0", {resp_data, resp_status, grant_id}); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_single();
      @(negedge clk);
      req_op_a[31:0] = 32'h40000000; req_op_b[31:0] = 32'h40800000;
      req_sub = '0; req_valid = 4'b0001; resp_ready = '0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL single_req_ready got=%b exp=0001", req_ready); end
      for (int k = 1; k <= L; k++) begin
         @(negedge clk);
         req_valid = '0;
         #1;
         checks++;
         if ({busy, resp_valid} !== 5'b10000) begin failures++; $display("[TB] FAIL single_busy_c%0d got=%b exp=10000", k, {busy, resp_valid}); end
         if (k == 1) begin
            checks++;
            if ({fpu_op_a, fpu_op_b} !== 64'h40000000_40800000) begin failures++; $display("[TB] FAIL single_fpu_ops got=%h exp=4000000040800000", {fpu_op_a, fpu_op_b}); end
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (resp_valid !== 4'b0001) begin failures++; $display("[TB] FAIL single_resp_valid_c6 got=%b exp=0001", resp_valid); end
      checks++;
      if (resp_data !== 32'h00800000) begin failures++; $display("[TB] FAIL single_resp_data got=%h exp=00800000", resp_data); end
      checks++;
      if (resp_status !== 4'b0001) begin failures++; $display("[TB] FAIL single_resp_status got=%b exp=0001", resp_status); end
      checks++;
      if (grant_id !== 2'd0) begin failures++; $display("[TB] FAIL single_grant_id got=%0d exp=0", grant_id); end
      resp_ready = 4'b0001;
      @(negedge clk);
      #1;
      checks++;
      if ({busy, resp_valid} !== 5'b00000) begin failures++; $display("[TB] FAIL single_handshake got=%b exp=00000", {busy, resp_valid}); end
      resp_ready = '0;
   endtask

   task automatic test_subtract();
      int n;
      @(negedge clk);
      req_op_a[63:32] = 32'h41400000; req_op_b[63:32] = 32'h40200000;
      req_sub = 4'b0010; req_valid = 4'b0010;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL sub_req_ready got=%b exp=0010", req_ready); end
      @(negedge clk);
      req_valid = '0; req_sub = '0;
      #1;
      checks++;
      if (fpu_op_b !== 32'hC0200000) begin failures++; $display("[TB] FAIL sub_fpu_op_b got=%h exp=c0200000", fpu_op_b); end
      wait_resp(n);
      checks++;
      if (n !== L) begin failures++; $display("[TB] FAIL sub_latency got=%0d exp=%0d", n, L); end
      checks++;
      if ({resp_valid, resp_data} !== {4'b0010, 32'h81600000}) begin failures++; $display("[TB] FAIL sub_resp got=%h exp=281600000", {resp_valid, resp_data}); end
      checks++;
      if (grant_id !== 2'd1) begin failures++; $display("[TB] FAIL sub_grant_id got=%0d exp=1", grant_id); end
      drain();
   endtask

   task automatic test_round_robin();
      int g;
      int cyc;
      int order[5];
      int when[5];
      do_reset();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         req_op_a[32*i +: 32] = 32'h3F800000 + i;
         req_op_b[32*i +: 32] = 32'h00010000 * (i + 1);
      end
      req_valid = 4'b1111; resp_ready = 4'b1111;
      g = 0; cyc = 0;
      while (g < 5 && cyc < 100) begin
         #1;
         if ((req_ready & req_valid) != '0) begin
            order[g] = -1;
            for (int i = 0; i < N; i++) if (req_ready[i]) order[g] = i;
            when[g] = cyc;
            g++;
         end
         @(negedge clk);
         cyc++;
      end
      req_valid = '0;
      checks++;
      if (g !== 5) begin failures++; $display("[TB] FAIL rr_grant_count got=%0d exp=5", g); end
      for (int i = 0; i < g; i++) begin
         checks++;
         if (order[i] !== i % N) begin failures++; $display("[TB] FAIL rr_order_%0d got=%0d exp=%0d", i, order[i], i % N); end
         if (i > 0) begin
            checks++;
            if (when[i] - when[i-1] !== L + 2) begin failures++; $display("[TB] FAIL rr_spacing_%0d got=%0d exp=%0d", i, when[i] - when[i-1], L + 2); end
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      int n;
      @(negedge clk);
      req_op_a[31:0] = 32'h11111111; req_op_b[31:0] = 32'h22220000;
      req_valid = 4'b0001; resp_ready = '0;
      @(negedge clk);
      req_op_a[63:32] = 32'h00000005; req_op_b[63:32] = 32'h00000003;
      req_valid = 4'b0010; resp_ready = 4'b1110;
      wait_resp(n);
      checks++;
      if ({resp_valid, resp_data} !== {4'b0001, 32'h33331111}) begin failures++; $display("[TB] FAIL bp_first_resp got=%h exp=133331111", {resp_valid, resp_data}); end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({resp_valid, resp_data} !== {4'b0001, 32'h33331111}) begin failures++; $display("[TB] FAIL bp_hold_%0d got=%h exp=133331111", k, {resp_valid, resp_data}); end
         checks++;
         if ({busy, req_ready} !== 5'b10000) begin failures++; $display("[TB] FAIL bp_stall_%0d got=%b exp=10000", k, {busy, req_ready}); end
      end
      resp_ready = 4'b0001;
      @(negedge clk);
      #1;
      checks++;
      if ({busy, req_ready} !== 5'b00010) begin failures++; $display("[TB] FAIL bp_next_accept got=%b exp=00010", {busy, req_ready}); end
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++;
      if ({busy, grant_id} !== 3'b101) begin failures++; $display("[TB] FAIL bp_next_grant got=%b exp=101", {busy, grant_id}); end
      drain();
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      req_op_a[95:64] = 32'h0000F000; req_op_b[95:64] = 32'h000000F0;
      req_valid = 4'b0100; resp_ready = '0;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin failures++; $display("[TB] FAIL rst_first_ready got=%b exp=0100", req_ready); end
      @(negedge clk);
      req_valid = 4'b1100;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({busy, resp_valid, req_ready, grant_id} !== 11'h0) begin failures++; $display("[TB] FAIL rst_ctrl_outputs got=%b exp=0", {busy, resp_valid, req_ready, grant_id}); end
      checks++;
      if ({fpu_op_a, fpu_op_b, resp_data, resp_status} !== 100'h0) begin failures++; $display("[TB] FAIL rst_data_outputs got=%h exp=0", {fpu_op_a, fpu_op_b, resp_data, resp_status}); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin failures++; $display("[TB] FAIL rst_priority got=%b exp=0100", req_ready); end
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++;
      if ({busy, grant_id} !== 3'b110) begin failures++; $display("[TB] FAIL rst_regrant got=%b exp=110", {busy, grant_id}); end
      drain();
   endtask

   task automatic test_operand_change();
      int n;
      @(negedge clk);
      req_op_a[127:96] = 32'h3F800000; req_op_b[127:96] = 32'h40400000;
      req_valid = 4'b1000;
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin failures++; $display("[TB] FAIL opchg_ready got=%b exp=1000", req_ready); end
      @(negedge clk);
      req_op_a[127:96] = 32'h12345678; req_op_b[127:96] = 32'hFFFFFFFF; req_valid = '0;
      #1;
      checks++;
      if (fpu_op_a !== 32'h3F800000) begin failures++; $display("[TB] FAIL opchg_fpu_op_a got=%h exp=3f800000", fpu_op_a); end
      wait_resp(n);
      checks++;
      if ({resp_valid, resp_data, grant_id} !== {4'b1000, 32'h7FC00000, 2'd3}) begin failures++; $display("[TB] FAIL opchg_resp got=%h exp=21ff000003", {resp_valid, resp_data, grant_id}); end
      drain();
      checks++;
      if (stub_errors !== 0) begin failures++; $display("[TB] FAIL stub_stability got=%0d exp=0", stub_errors); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_subtract();
      test_round_robin();
      test_backpressure();
      test_reset_midop();
      test_operand_change();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout got=running exp=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
